// File: rtl/core_types_pkg.sv
// -----------------------------------------------------------------------------
// core_types_pkg
//   Shared fetch-stage types and constants. This slice holds the return address
//   stack (RAS) geometry, its reset content, and the checkpoint record that the
//   branch checkpoint storage keeps per in-flight branch.
//
//   Contents:
//     RAS_ENTRIES       stack depth (power of 2)
//     RAS_INDEX_WIDTH   head pointer width
//     RAS_COUNT_WIDTH   occupancy width (0..RAS_ENTRIES inclusive)
//     RAS_TARGET_WIDTH  stored target width (PC[31:1])
//     INIT_PC           reset content of every RAS entry (stored as INIT_PC[31:1])
//     INIT_TARGET       INIT_PC[31:1], the value actually held in the array
//     ras_ckpt_t        {index, count, target} checkpoint record
//     ras_make_ckpt()   convenience constructor for ras_ckpt_t
// -----------------------------------------------------------------------------
package core_types_pkg;

  localparam int unsigned RAS_ENTRIES      = 8;
  localparam int unsigned RAS_INDEX_WIDTH  = $clog2(RAS_ENTRIES);
  localparam int unsigned RAS_COUNT_WIDTH  = RAS_INDEX_WIDTH + 1;
  localparam int unsigned RAS_TARGET_WIDTH = 31;

  localparam logic [31:0] INIT_PC = 32'h8000_0000;
  localparam logic [RAS_TARGET_WIDTH-1:0] INIT_TARGET = INIT_PC[31:1];

  // Snapshot taken alongside each predicted branch; restored on mispredict.
  typedef struct packed {
    logic [RAS_INDEX_WIDTH-1:0]  index;
    logic [RAS_COUNT_WIDTH-1:0]  count;
    logic [RAS_TARGET_WIDTH-1:0] target;
  } ras_ckpt_t;

  function automatic ras_ckpt_t ras_make_ckpt(
    input logic [RAS_INDEX_WIDTH-1:0]  index,
    input logic [RAS_COUNT_WIDTH-1:0]  count,
    input logic [RAS_TARGET_WIDTH-1:0] target
  );
    ras_ckpt_t c;
    c.index  = index;
    c.count  = count;
    c.target = target;
    return c;
  endfunction

endpackage

// File: rtl/ras.sv
// -----------------------------------------------------------------------------
// ras
//   Return address stack for the fetch predictors. Fetch pushes the link
//   address PC[31:1] on predicted calls and pops the top as the target on
//   predicted returns. Head index and occupancy are exported so the branch
//   checkpoint logic can snapshot them; the backend restores them through the
//   update port on mispredict/flush. Pure state, no prediction logic.
//
//   Ports:
//     CLK            clock (single domain)
//     nRST           asynchronous active-low reset
//     push_valid     push push_target this cycle
//     push_target    link address PC[31:1]
//     pop_valid      pop the top this cycle
//     update_valid   restore a checkpoint (wins over push/pop)
//     update_index   checkpointed head
//     update_count   checkpointed occupancy (0..RAS_ENTRIES)
//     update_target  checkpointed top target (only used with RAS_REPAIR_TOP_EN)
//     ras_target     array[head], combinational from registered state
//     ras_index      current head
//     ras_count      current occupancy
//     ras_empty      ras_count == 0
//
//   Configuration macro:
//     RAS_REPAIR_TOP_EN  when defined, an update also writes
//                        array[update_index] <= update_target, repairing a top
//                        entry clobbered by a wrong-path pop+push. When
//                        undefined, update_target is ignored.
//
//   Handshake: push_valid/pop_valid/update_valid are single-cycle qualifiers
//   with no ready; every asserted request is accepted on the next CLK edge and
//   its effect is visible on the outputs right after that edge.
// -----------------------------------------------------------------------------
module ras
  import core_types_pkg::*;
(
  input  logic                        CLK,
  input  logic                        nRST,
  input  logic                        push_valid,
  input  logic [RAS_TARGET_WIDTH-1:0] push_target,
  input  logic                        pop_valid,
  input  logic                        update_valid,
  input  logic [RAS_INDEX_WIDTH-1:0]  update_index,
  input  logic [RAS_COUNT_WIDTH-1:0]  update_count,
  input  logic [RAS_TARGET_WIDTH-1:0] update_target,
  output logic [RAS_TARGET_WIDTH-1:0] ras_target,
  output logic [RAS_INDEX_WIDTH-1:0]  ras_index,
  output logic [RAS_COUNT_WIDTH-1:0]  ras_count,
  output logic                        ras_empty
);

  localparam logic [RAS_COUNT_WIDTH-1:0] COUNT_FULL = RAS_COUNT_WIDTH'(RAS_ENTRIES);
  localparam logic [RAS_INDEX_WIDTH-1:0] IDX_ONE    = RAS_INDEX_WIDTH'(1);
  localparam logic [RAS_COUNT_WIDTH-1:0] CNT_ONE    = RAS_COUNT_WIDTH'(1);

  logic [RAS_TARGET_WIDTH-1:0] entries [RAS_ENTRIES];
  logic [RAS_INDEX_WIDTH-1:0]  head, head_nxt;
  logic [RAS_COUNT_WIDTH-1:0]  count, count_nxt;

  // Single array write port: at most one entry changes per cycle.
  logic                        wr_en;
  logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
  logic [RAS_TARGET_WIDTH-1:0] wr_data;

`ifndef RAS_REPAIR_TOP_EN
  logic unused_update_target;
  assign unused_update_target = ^update_target;
`endif

  always_comb begin
    head_nxt  = head;
    count_nxt = count;
    wr_en     = 1'b0;
    wr_idx    = head;
    wr_data   = push_target;

    if (update_valid) begin
      head_nxt  = update_index;
      count_nxt = update_count;
`ifdef RAS_REPAIR_TOP_EN
      wr_en     = 1'b1;
      wr_idx    = update_index;
      wr_data   = update_target;
`endif
    end else if (push_valid && pop_valid) begin
      // Pop-then-push: replace the top in place, even when the stack is empty.
      wr_en = 1'b1;
    end else if (push_valid) begin
      // Pointer wraps naturally; when full this overwrites the oldest entry.
      head_nxt  = head + IDX_ONE;
      wr_en     = 1'b1;
      wr_idx    = head + IDX_ONE;
      count_nxt = (count == COUNT_FULL) ? count : count + CNT_ONE;
    end else if (pop_valid && (count != '0)) begin
      head_nxt  = head - IDX_ONE;
      count_nxt = count - CNT_ONE;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      count <= '0;
      for (int i = 0; i < RAS_ENTRIES; i++) begin
        entries[i] <= INIT_TARGET;
      end
    end else begin
      head  <= head_nxt;
      count <= count_nxt;
      if (wr_en) begin
        entries[wr_idx] <= wr_data;
      end
    end
  end

  assign ras_target = entries[head];
  assign ras_index  = head;
  assign ras_count  = count;
  assign ras_empty  = (count == '0);

endmodule

// File: tb/tb_ras.sv
// -----------------------------------------------------------------------------
// tb_ras
//   Directed, table-driven bench for the return address stack. Each record
//   gives one cycle of inputs (or an asynchronous reset pulse) and the outputs
//   expected right after it. A few multi-cycle corner cases (top repair after a
//   wrong-path pop+push, reset asserted with requests pending) are written out
//   by hand and use the same apply/compare task.
// -----------------------------------------------------------------------------
module tb_ras;
  import core_types_pkg::*;

  // ---------------------------------------------------------------- clock/reset
  logic CLK = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  // ---------------------------------------------------------------- DUT
  logic                        push_valid = 1'b0;
  logic [RAS_TARGET_WIDTH-1:0] push_target = '0;
  logic                        pop_valid = 1'b0;
  logic                        update_valid = 1'b0;
  logic [RAS_INDEX_WIDTH-1:0]  update_index = '0;
  logic [RAS_COUNT_WIDTH-1:0]  update_count = '0;
  logic [RAS_TARGET_WIDTH-1:0] update_target = '0;
  logic [RAS_TARGET_WIDTH-1:0] ras_target;
  logic [RAS_INDEX_WIDTH-1:0]  ras_index;
  logic [RAS_COUNT_WIDTH-1:0]  ras_count;
  logic                        ras_empty;

  ras dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .push_valid    (push_valid),
    .push_target   (push_target),
    .pop_valid     (pop_valid),
    .update_valid  (update_valid),
    .update_index  (update_index),
    .update_count  (update_count),
    .update_target (update_target),
    .ras_target    (ras_target),
    .ras_index     (ras_index),
    .ras_count     (ras_count),
    .ras_empty     (ras_empty)
  );

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit                          rst;
    bit                          push;
    logic [RAS_TARGET_WIDTH-1:0] push_t;
    bit                          pop;
    bit                          upd;
    logic [RAS_INDEX_WIDTH-1:0]  u_idx;
    logic [RAS_COUNT_WIDTH-1:0]  u_cnt;
    logic [RAS_TARGET_WIDTH-1:0] u_tgt;
    logic [RAS_TARGET_WIDTH-1:0] e_tgt;
    logic [RAS_INDEX_WIDTH-1:0]  e_idx;
    logic [RAS_COUNT_WIDTH-1:0]  e_cnt;
  } vec_t;

  vec_t vecs[$];

  int n_vec = 0;
  int n_err = 0;

  localparam logic [RAS_TARGET_WIDTH-1:0] RST_TGT = 31'h4000_0000;

  function automatic vec_t mk(
    input bit rst, input bit push, input logic [30:0] push_t, input bit pop,
    input bit upd, input logic [2:0] u_idx, input logic [3:0] u_cnt,
    input logic [30:0] u_tgt,
    input logic [30:0] e_tgt, input logic [2:0] e_idx, input logic [3:0] e_cnt
  );
    vec_t v;
    v.rst = rst; v.push = push; v.push_t = push_t; v.pop = pop;
    v.upd = upd; v.u_idx = u_idx; v.u_cnt = u_cnt; v.u_tgt = u_tgt;
    v.e_tgt = e_tgt; v.e_idx = e_idx; v.e_cnt = e_cnt;
    return v;
  endfunction

  // Short-hands for the common record shapes.
  function automatic vec_t v_rst();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, RST_TGT, 0, 0);
  endfunction
  function automatic vec_t v_push(input logic [30:0] t, input logic [30:0] et,
                                  input logic [2:0] ei, input logic [3:0] ec);
    return mk(0, 1, t, 0, 0, 0, 0, 0, et, ei, ec);
  endfunction
  function automatic vec_t v_pop(input logic [30:0] et, input logic [2:0] ei,
                                 input logic [3:0] ec);
    return mk(0, 0, 0, 1, 0, 0, 0, 0, et, ei, ec);
  endfunction
  function automatic vec_t v_pp(input logic [30:0] t, input logic [30:0] et,
                                input logic [2:0] ei, input logic [3:0] ec);
    return mk(0, 1, t, 1, 0, 0, 0, 0, et, ei, ec);
  endfunction

  // ---------------------------------------------------------------- checker
  task automatic check(input string name, input int id, input vec_t v);
    logic e_empty;
    e_empty = (v.e_cnt == 4'd0);
    n_vec++;
    if (ras_target !== v.e_tgt || ras_index !== v.e_idx ||
        ras_count !== v.e_cnt || ras_empty !== e_empty) begin
      n_err++;
      $display("FAIL %s #%0d: got target=%h index=%0d count=%0d empty=%0b, expected target=%h index=%0d count=%0d empty=%0b",
               name, id, ras_target, ras_index, ras_count, ras_empty,
               v.e_tgt, v.e_idx, v.e_cnt, e_empty);
    end
  endtask

  // ---------------------------------------------------------------- driver
  // Called just after a negedge. A reset record pulses nRST with no clock edge
  // in between so the asynchronous path alone must produce the reset values.
  task automatic apply(input string name, input int id, input vec_t v);
    if (v.rst) begin
      nRST = 1'b0;
      #1;
      check(name, id, v);
      #1;
      nRST = 1'b1;
    end else begin
      push_valid    = v.push;
      push_target   = v.push_t;
      pop_valid     = v.pop;
      update_valid  = v.upd;
      update_index  = v.u_idx;
      update_count  = v.u_cnt;
      update_target = v.u_tgt;
      @(posedge CLK);
      #1;
      check(name, id, v);
      push_valid   = 1'b0;
      pop_valid    = 1'b0;
      update_valid = 1'b0;
    end
    @(negedge CLK);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin : main
    vec_t hv;
    logic [RAS_TARGET_WIDTH-1:0] slot5_after_update;
    logic [RAS_TARGET_WIDTH-1:0] repaired_top;

`ifdef RAS_REPAIR_TOP_EN
    slot5_after_update = 31'h7;
    repaired_top       = 31'hB;
`else
    slot5_after_update = RST_TGT;
    repaired_top       = 31'hD;
`endif

    // Reset state.
    vecs.push_back(v_rst());
    // Basic push/pop.
    vecs.push_back(v_push(31'h100, 31'h100, 1, 1));
    vecs.push_back(v_push(31'h200, 31'h200, 2, 2));
    vecs.push_back(v_push(31'h300, 31'h300, 3, 3));
    vecs.push_back(v_pop(31'h200, 2, 2));
    vecs.push_back(v_pop(31'h100, 1, 1));
    // Overflow: push 1..9 from empty, count saturates at 8, 9 overwrites 1.
    vecs.push_back(v_rst());
    for (int k = 1; k <= 9; k++) begin
      vecs.push_back(v_push(31'(k), 31'(k), 3'(k), (k > 8) ? 4'd8 : 4'(k)));
    end
    // Drain: head walks 1,0,7,...,2,1; entry 1 now holds 9.
    vecs.push_back(v_pop(31'h8, 0, 7));
    for (int k = 7; k >= 2; k--) begin
      vecs.push_back(v_pop(31'(k), 3'(k), 4'(k - 1)));
    end
    vecs.push_back(v_pop(31'h9, 1, 0));
    // Underflow: no state change, stale top stays visible.
    vecs.push_back(v_pop(31'h9, 1, 0));
    // Pop+push while empty replaces array[head], count stays 0.
    vecs.push_back(v_pp(31'h55, 31'h55, 1, 0));
    // Coroutine return with one entry.
    vecs.push_back(v_rst());
    vecs.push_back(v_push(31'h100, 31'h100, 1, 1));
    vecs.push_back(v_pp(31'h500, 31'h500, 1, 1));
    // Checkpoint restore after wrong-path push then pop+push above the checkpoint.
    vecs.push_back(v_rst());
    vecs.push_back(v_push(31'hA, 31'hA, 1, 1));
    vecs.push_back(v_push(31'hB, 31'hB, 2, 2));
    vecs.push_back(v_push(31'hC, 31'hC, 3, 3));
    vecs.push_back(v_pp(31'hD, 31'hD, 3, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 2, 31'hB, 31'hB, 2, 2));
    // Update wins over a simultaneous push.
    vecs.push_back(mk(0, 1, 31'h9, 0, 1, 5, 3, 31'h7, slot5_after_update, 5, 3));
    vecs.push_back(v_push(31'hE, 31'hE, 6, 4));
    vecs.push_back(v_pop(slot5_after_update, 5, 3));
    // Update wins over a simultaneous pop; restore a full stack.
    vecs.push_back(mk(0, 0, 0, 1, 1, 6, 8, 31'h3, 31'hE, 6, 8));
`ifdef RAS_REPAIR_TOP_EN
    vecs[$].e_tgt = 31'h3;
`endif
    vecs.push_back(v_push(31'h21, 31'h21, 7, 8));
    vecs.push_back(v_rst());

    @(negedge CLK);
    nRST = 1'b0;
    #2;
    nRST = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < vecs.size(); i++) begin
      apply("table", i, vecs[i]);
    end

    // Wrong-path pop then push clobbers the checkpointed top entry; the
    // restore brings back index/count, and the target only with repair on.
    apply("repair", 0, v_rst());
    apply("repair", 1, v_push(31'hA, 31'hA, 1, 1));
    apply("repair", 2, v_push(31'hB, 31'hB, 2, 2));
    apply("repair", 3, v_pop(31'hA, 1, 1));
    apply("repair", 4, v_push(31'hD, 31'hD, 2, 2));
    apply("repair", 5, mk(0, 0, 0, 0, 1, 2, 2, 31'hB, repaired_top, 2, 2));

    // Reset asserted mid-cycle while requests are held active: reset values
    // appear immediately and persist across a clock edge.
    apply("midrst", 0, v_push(31'h11, 31'h11, 3, 3));
    push_valid   = 1'b1;
    push_target  = 31'h77;
    pop_valid    = 1'b0;
    update_valid = 1'b0;
    #2;
    nRST = 1'b0;
    #1;
    hv = v_rst();
    check("midrst", 1, hv);
    @(posedge CLK);
    #1;
    check("midrst", 2, hv);
    push_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    apply("midrst", 3, v_push(31'h12, 31'h12, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
